// File: rtl/rle_token_gen.sv
// Run-length tokeniser feeding the 64-bit shift-concatenation stage.
// Emits one literal or run token per cycle, LSB-aligned, with msg_fin on each message's last token.
module rle_token_gen #(
  parameter int RUN_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  input  logic        msg_end,
  input  logic        stall,
  output logic        byte_ready,
  output logic [63:0] data_out,
  output logic [6:0]  valid_bits,
  output logic        msg_fin
);

  localparam int                CNT_W    = RUN_W + 1;
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'((1 << RUN_W) + 1);
  localparam logic [6:0]        LIT_LEN  = 7'd9;
  localparam logic [6:0]        RUN_LEN  = 7'(9 + RUN_W);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN,
    GAP
  } state_e;

  state_e            state_q, state_d;
  logic [7:0]        held_q, held_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [63:0]       tok_data_q, tok_data_d;
  logic [6:0]        tok_len_q, tok_len_d;
  logic              tok_fin_q, tok_fin_d;
  logic              tok_pend_q, tok_pend_d;

  logic present;
  logic accept;

  // A run of one is a literal; longer runs store length-2 in the field above the byte.
  function automatic logic [63:0] build_token(input logic [7:0] b, input logic [CNT_W-1:0] cnt);
    logic [63:0] t;
    t = '0;
    if (cnt == CNT_ONE) begin
      t[8:0] = {b, 1'b0};
    end else begin
      t[8:0] = {b, 1'b1};
      t[8+RUN_W:9] = RUN_W'(cnt - CNT_W'(2));
    end
    return t;
  endfunction

  function automatic logic [6:0] token_len(input logic [CNT_W-1:0] cnt);
    return (cnt == CNT_ONE) ? LIT_LEN : RUN_LEN;
  endfunction

  assign present    = tok_pend_q && !stall;
  assign byte_ready = rst && !stall && ((state_q == IDLE) || (state_q == RUN));
  assign accept     = byte_valid && byte_ready;
  assign data_out   = present ? tok_data_q : 64'd0;
  assign valid_bits = present ? tok_len_q : 7'd0;
  assign msg_fin    = present && tok_fin_q;

  // A presented token is consumed at the edge; a load at the same edge simply replaces it.
  always_comb begin
    state_d    = state_q;
    held_d     = held_q;
    count_d    = count_q;
    tok_data_d = tok_data_q;
    tok_len_d  = tok_len_q;
    tok_fin_d  = tok_fin_q;
    tok_pend_d = tok_pend_q && !present;

    case (state_q)
      IDLE: begin
        if (accept) begin
          held_d  = byte_in;
          count_d = CNT_ONE;
          state_d = msg_end ? FIN : RUN;
        end
      end

      RUN: begin
        if (accept) begin
          if ((byte_in == held_q) && (count_q < CNT_MAX)) begin
            count_d = count_q + CNT_ONE;
          end else begin
            tok_data_d = build_token(held_q, count_q);
            tok_len_d  = token_len(count_q);
            tok_fin_d  = 1'b0;
            tok_pend_d = 1'b1;
            held_d     = byte_in;
            count_d    = CNT_ONE;
          end
          if (msg_end) begin
            state_d = FIN;
          end
        end
      end

      // Unstalled means any pending token is consumed this edge, so the slot is free.
      FIN: begin
        if (!stall) begin
          tok_data_d = build_token(held_q, count_q);
          tok_len_d  = token_len(count_q);
          tok_fin_d  = 1'b1;
          tok_pend_d = 1'b1;
          held_d     = 8'd0;
          count_d    = '0;
          state_d    = GAP;
        end
      end

      GAP: begin
        if (!stall && !tok_pend_q) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      held_q     <= 8'd0;
      count_q    <= '0;
      tok_data_q <= 64'd0;
      tok_len_q  <= 7'd0;
      tok_fin_q  <= 1'b0;
      tok_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      held_q     <= held_d;
      count_q    <= count_d;
      tok_data_q <= tok_data_d;
      tok_len_q  <= tok_len_d;
      tok_fin_q  <= tok_fin_d;
      tok_pend_q <= tok_pend_d;
    end
  end

endmodule

// File: tb/tb_rle_token_gen.sv
// Directed bench for rle_token_gen with a token decoder for the random-stream section.
module tb_rle_token_gen;

  logic        clk;
  logic        rst;
  logic [7:0]  byteIn;
  logic        byteValid;
  logic        msgEnd;
  logic        stall;
  logic        byteReady;
  logic [63:0] dataOut;
  logic [6:0]  validBits;
  logic        msgFin;

  int checks   = 0;
  int failures = 0;

  bit         monEn    = 1'b0;
  logic [7:0] recvQ[$];
  logic [7:0] sentQ[$];
  int         finCount = 0;
  int         badTok   = 0;

  rle_token_gen #(.RUN_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .byte_in    (byteIn),
    .byte_valid (byteValid),
    .msg_end    (msgEnd),
    .stall      (stall),
    .byte_ready (byteReady),
    .data_out   (dataOut),
    .valid_bits (validBits),
    .msg_fin    (msgFin)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Decodes every presented token back into bytes while the random section runs.
  always begin
    @(negedge clk);
    #2;
    if (monEn) begin
      if (validBits == 7'd9) begin
        if (dataOut[0] !== 1'b0 || (dataOut >> 9) != 64'd0) badTok++;
        recvQ.push_back(dataOut[8:1]);
      end else if (validBits == 7'd17) begin
        if (dataOut[0] !== 1'b1 || (dataOut >> 17) != 64'd0) badTok++;
        for (int k = 0; k < int'(dataOut[16:9]) + 2; k++) recvQ.push_back(dataOut[8:1]);
      end else if (validBits != 7'd0) begin
        badTok++;
      end
      if (msgFin === 1'b1) finCount++;
      if (msgFin === 1'b1 && validBits == 7'd0) badTok++;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checkToken(input string tag, input logic [63:0] expData,
                            input logic [6:0] expBits, input logic expFin);
    checkOutput({tag, "_data"}, dataOut, expData);
    checkOutput({tag, "_bits"}, {57'd0, validBits}, {57'd0, expBits});
    checkOutput({tag, "_fin"}, {63'd0, msgFin}, {63'd0, expFin});
  endtask

  // Offers one byte until accepted; returns just after the next falling edge.
  task automatic applyStimulus(input logic [7:0] b, input logic e, input bit rndStall);
    bit acc;
    acc = 1'b0;
    byteIn    = b;
    byteValid = 1'b1;
    msgEnd    = e;
    for (int t = 0; t < 300; t++) begin
      if (rndStall) stall = ($urandom_range(0, 3) == 0);
      #1;
      acc = (byteReady === 1'b1);
      @(posedge clk);
      if (acc) break;
      @(negedge clk);
    end
    checks++;
    assert (acc) else begin
      failures++;
      $error("[TB] FAIL accept_timeout observed=%0d expected=1", acc);
    end
    @(negedge clk);
    byteValid = 1'b0;
    msgEnd    = 1'b0;
    if (rndStall) stall = 1'b0;
    #1;
  endtask

  initial begin
    rst       = 1'b0;
    byteIn    = 8'd0;
    byteValid = 1'b0;
    msgEnd    = 1'b0;
    stall     = 1'b0;
    $display("[TB] start");

    repeat (2) tick();
    checkToken("reset", 64'd0, 7'd0, 1'b0);
    checkOutput("reset_ready", {63'd0, byteReady}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("idle_ready", {63'd0, byteReady}, 64'd1);

    // Two literals; the second closes the message.
    applyStimulus(8'h41, 1'b0, 1'b0);
    applyStimulus(8'h42, 1'b1, 1'b0);
    checkToken("t1_lit41", 64'h082, 7'd9, 1'b0);
    tick();
    checkToken("t1_lit42", 64'h084, 7'd9, 1'b1);
    tick();
    checkToken("t1_gap", 64'd0, 7'd0, 1'b0);
    checkOutput("t1_gap_ready", {63'd0, byteReady}, 64'd0);
    tick();
    checkOutput("t1_idle_ready", {63'd0, byteReady}, 64'd1);

    // Five equal bytes extending to the end give a single fin run token.
    for (int i = 0; i < 5; i++) applyStimulus(8'h55, (i == 4), 1'b0);
    checkToken("t2_fin_wait", 64'd0, 7'd0, 1'b0);
    tick();
    checkToken("t2_run5", 64'h6AB, 7'd17, 1'b1);
    tick();
    checkOutput("t2_gap_ready", {63'd0, byteReady}, 64'd0);
    tick();

    // 260 bytes saturate once (257) and leave a run of 3.
    for (int i = 1; i <= 260; i++) begin
      applyStimulus(8'hFF, (i == 260), 1'b0);
      if (i == 258) checkToken("t3_sat", 64'h1FFFF, 7'd17, 1'b0);
    end
    tick();
    checkToken("t3_run3", 64'h3FF, 7'd17, 1'b1);
    repeat (2) tick();

    // Break token is held through a 3-cycle stall and shown exactly once.
    for (int i = 0; i < 3; i++) applyStimulus(8'h20, 1'b0, 1'b0);
    applyStimulus(8'h10, 1'b1, 1'b0);
    stall = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      checkToken("t4_stalled", 64'd0, 7'd0, 1'b0);
      checkOutput("t4_stalled_ready", {63'd0, byteReady}, 64'd0);
      if (i < 2) tick();
    end
    @(negedge clk);
    stall = 1'b0;
    #1;
    checkToken("t4_run3", 64'h241, 7'd17, 1'b0);
    tick();
    checkToken("t4_lit10", 64'h020, 7'd9, 1'b1);
    tick();
    checkToken("t4_gap", 64'd0, 7'd0, 1'b0);
    tick();

    // Reset lands while a run-of-4 token is on the bus, before it is consumed.
    for (int i = 0; i < 4; i++) applyStimulus(8'h30, 1'b0, 1'b0);
    applyStimulus(8'h31, 1'b0, 1'b0);
    checkToken("t5_pending", 64'h461, 7'd17, 1'b0);
    rst = 1'b0;
    #1;
    checkToken("t5_async", 64'd0, 7'd0, 1'b0);
    checkOutput("t5_async_ready", {63'd0, byteReady}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkToken("t5_after", 64'd0, 7'd0, 1'b0);
    applyStimulus(8'h01, 1'b1, 1'b0);
    checkToken("t5_fin_wait", 64'd0, 7'd0, 1'b0);
    tick();
    checkToken("t5_lit01", 64'h002, 7'd9, 1'b1);
    repeat (2) tick();

    // Random short messages over a small alphabet with random stall.
    monEn = 1'b1;
    for (int m = 0; m < 4; m++) begin
      int len;
      len = $urandom_range(1, 40);
      for (int i = 0; i < len; i++) begin
        logic [7:0] b;
        b = 8'hA0 + 8'($urandom_range(0, 2));
        sentQ.push_back(b);
        applyStimulus(b, (i == len - 1), 1'b1);
      end
    end
    stall = 1'b0;
    repeat (10) tick();
    monEn = 1'b0;

    checkOutput("t6_len", 64'(recvQ.size()), 64'(sentQ.size()));
    begin
      int bad;
      bad = 0;
      for (int i = 0; i < sentQ.size() && i < recvQ.size(); i++)
        if (recvQ[i] !== sentQ[i]) bad++;
      checkOutput("t6_bytes_bad", 64'(bad), 64'd0);
    end
    checkOutput("t6_fin_count", 64'(finCount), 64'd4);
    checkOutput("t6_bad_tokens", 64'(badTok), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
